// File: rtl/hook_motion.sv
// hook_motion: per-tick hook position / line-cut state machine feeding the hook renderer
module hook_motion #(
  parameter logic [13:0] TOP_V         = 14'd620,
  parameter logic [13:0] BOTTOM_V      = 14'd4700,
  parameter logic [13:0] HOOK_X        = 14'd2790,
  parameter logic [13:0] DROP_STEP     = 14'd20,
  parameter logic [13:0] REEL_STEP     = 14'd30,
  parameter logic [13:0] SINK_STEP     = 14'd10,
  parameter logic [13:0] DRIFT_STEP    = 14'd5,
  parameter int          RESPAWN_TICKS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        reel,
  input  logic        cut_req,
  output logic [13:0] h_position,
  output logic [13:0] v_position,
  output logic        cut,
  output logic [9:0]  cut_v,
  output logic [2:0]  state,
  output logic        done,
  output logic        lost
);
  typedef enum logic [2:0] {IDLE = 3'd0, DROP = 3'd1, REEL = 3'd2, CUT = 3'd3, RESPAWN = 3'd4} state_t;
  localparam logic [13:0] H_MAX = 14'd6390;
  localparam int CW = $clog2(RESPAWN_TICKS);
  localparam logic [9:0] REST_ROW = 10'(TOP_V / 14'd10);
  state_t st;
  logic [CW-1:0] cnt;
  logic [13:0] v_drop, v_reel, v_sink, h_drift;
  logic [9:0] row;
  // clamps are resolved before writeback so positions never wrap
  always_comb begin
    v_drop  = (v_position >= BOTTOM_V - DROP_STEP) ? BOTTOM_V : v_position + DROP_STEP;
    v_reel  = (v_position - TOP_V >= REEL_STEP) ? v_position - REEL_STEP : TOP_V;
    v_sink  = (v_position >= BOTTOM_V - SINK_STEP) ? BOTTOM_V : v_position + SINK_STEP;
    h_drift = (h_position >= H_MAX - DRIFT_STEP) ? H_MAX : h_position + DRIFT_STEP;
    row     = 10'(v_position / 14'd10);
  end
  assign state = st;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      h_position <= HOOK_X;
      v_position <= TOP_V;
      cut        <= 1'b0;
      cut_v      <= REST_ROW;
      done       <= 1'b0;
      lost       <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      lost <= 1'b0;
      case (st)
        IDLE: if (start) st <= DROP;
        DROP: begin
          if (cut_req) begin
            st    <= CUT;
            cut   <= 1'b1;
            cut_v <= row;
          end else if (reel) st <= REEL;
          else if (tick) v_position <= v_drop;
        end
        REEL: begin
          if (cut_req) begin
            st    <= CUT;
            cut   <= 1'b1;
            cut_v <= row;
          end else if (tick) begin
            v_position <= v_reel;
            if (v_reel == TOP_V) begin
              st   <= IDLE;
              done <= 1'b1;
            end
          end
        end
        CUT: if (tick) begin
          v_position <= v_sink;
          h_position <= h_drift;
          if (v_sink == BOTTOM_V) begin
            st  <= RESPAWN;
            cnt <= '0;
          end
        end
        RESPAWN: if (tick) begin
          if (cnt == CW'(RESPAWN_TICKS - 1)) begin
            st         <= IDLE;
            cut        <= 1'b0;
            h_position <= HOOK_X;
            v_position <= TOP_V;
            cut_v      <= REST_ROW;
            lost       <= 1'b1;
          end else cnt <= cnt + CW'(1);
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hook_motion.sv
// tb_hook_motion: directed plan plus random pulses checked against an integer reference model
module tb_hook_motion;
  logic clk, rst, tick, start, reel, cut_req;
  logic [13:0] h_position, v_position;
  logic cut, done, lost;
  logic [9:0] cut_v;
  logic [2:0] state;
  int checks = 0, failures = 0, done_cnt = 0, lost_cnt = 0;
  int ms, mv, mh, mcut, mcv, mticks, mdone, mlost;

  hook_motion dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .reel(reel), .cut_req(cut_req),
    .h_position(h_position), .v_position(v_position), .cut(cut), .cut_v(cut_v),
    .state(state), .done(done), .lost(lost)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return a < b ? a : b;
  endfunction

  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction

  // Reference: integer positions, the hook sits in RESPAWN for exactly 60 ticks
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms = 0; mv = 620; mh = 2790; mcut = 0; mcv = 62; mticks = 0; mdone = 0; mlost = 0;
    end else begin
      mdone = 0;
      mlost = 0;
      if (ms == 0) begin
        if (start) ms = 1;
      end else if (ms == 1 || ms == 2) begin
        if (cut_req) begin
          ms = 3; mcut = 1; mcv = mv / 10;
        end else if (ms == 1 && reel) ms = 2;
        else if (tick && ms == 1) mv = min2(mv + 20, 4700);
        else if (tick) begin
          mv = max2(mv - 30, 620);
          if (mv == 620) begin ms = 0; mdone = 1; end
        end
      end else if (ms == 3) begin
        if (tick) begin
          mv = min2(mv + 10, 4700);
          mh = min2(mh + 5, 6390);
          if (mv == 4700) begin ms = 4; mticks = 0; end
        end
      end else if (tick) begin
        mticks++;
        if (mticks == 60) begin
          ms = 0; mcut = 0; mh = 2790; mv = 620; mcv = 62; mlost = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("state", int'(state), ms);
    chk("v_position", int'(v_position), mv);
    chk("h_position", int'(h_position), mh);
    chk("cut", int'(cut), mcut);
    chk("cut_v", int'(cut_v), mcv);
    chk("done", int'(done), mdone);
    chk("lost", int'(lost), mlost);
    if (done) done_cnt++;
    if (lost) lost_cnt++;
  end

  task automatic cyc(input logic t, input logic s, input logic r, input logic c);
    @(negedge clk);
    tick = t; start = s; reel = r; cut_req = c;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1, 0, 0, 0);
  endtask

  task automatic settle();
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; tick = 0; start = 0; reel = 0; cut_req = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    settle();
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_v", int'(v_position), 620);
    chk("lit_reset_h", int'(h_position), 2790);
    chk("lit_reset_cut_v", int'(cut_v), 62);
    cyc(0, 1, 0, 0);
    ticks(10);
    settle();
    chk("lit_drop10_state", int'(state), 1);
    chk("lit_drop10_v", int'(v_position), 820);
    chk("lit_drop10_h", int'(h_position), 2790);
    chk("lit_drop10_cut", int'(cut), 0);
    ticks(240);
    settle();
    chk("lit_bottom_v", int'(v_position), 4700);
    chk("lit_bottom_state", int'(state), 1);
    cyc(0, 0, 1, 0);
    ticks(135);
    settle();
    chk("lit_reel135_state", int'(state), 2);
    chk("lit_reel135_done_cnt", done_cnt, 0);
    ticks(1);
    settle();
    chk("lit_reel136_state", int'(state), 0);
    chk("lit_reel136_v", int'(v_position), 620);
    chk("lit_reel136_done", int'(done), 1);
    chk("lit_reel136_done_cnt", done_cnt, 1);
    cyc(0, 1, 0, 0);
    ticks(50);
    settle();
    chk("lit_drop50_v", int'(v_position), 1620);
    cyc(1, 0, 1, 1);
    settle();
    chk("lit_cut_state", int'(state), 3);
    chk("lit_cut_cut", int'(cut), 1);
    chk("lit_cut_cut_v", int'(cut_v), 162);
    chk("lit_cut_v", int'(v_position), 1620);
    ticks(308);
    settle();
    chk("lit_sink_v", int'(v_position), 4700);
    chk("lit_sink_h", int'(h_position), 4330);
    chk("lit_sink_state", int'(state), 4);
    ticks(59);
    settle();
    chk("lit_resp59_state", int'(state), 4);
    chk("lit_resp59_lost_cnt", lost_cnt, 0);
    ticks(1);
    settle();
    chk("lit_resp60_state", int'(state), 0);
    chk("lit_resp60_cut", int'(cut), 0);
    chk("lit_resp60_v", int'(v_position), 620);
    chk("lit_resp60_h", int'(h_position), 2790);
    chk("lit_resp60_cut_v", int'(cut_v), 62);
    chk("lit_resp60_lost", int'(lost), 1);
    chk("lit_resp60_lost_cnt", lost_cnt, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 1);
    settle();
    chk("lit_idle_state", int'(state), 0);
    chk("lit_idle_v", int'(v_position), 620);
    chk("lit_idle_cut", int'(cut), 0);
    cyc(0, 1, 0, 0);
    ticks(5);
    cyc(1, 0, 0, 1);
    ticks(3);
    settle();
    chk("lit_precut_state", int'(state), 3);
    #2 rst = 1;
    #1;
    chk("lit_async_state", int'(state), 0);
    chk("lit_async_v", int'(v_position), 620);
    chk("lit_async_h", int'(h_position), 2790);
    chk("lit_async_cut", int'(cut), 0);
    chk("lit_async_cut_v", int'(cut_v), 62);
    chk("lit_async_done", int'(done), 0);
    chk("lit_async_lost", int'(lost), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (30000)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
    settle();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
